// File: rtl/router_pkg.sv
// Shared definitions for the router packet source: header field layout,
// illegal destination code and transmit state encoding.
package router_pkg;

  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_DEST_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  localparam logic [1:0] DEST_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PLD,
    ST_PAR,
    ST_ERRW,
    ST_GAP
  } tx_state_t;

endpackage

// File: rtl/router_pkt_tx_if.sv
// Host request, payload stream and router-side signals of the packet source.
// slave = packet source view, master = host/router environment view.
interface router_pkt_tx_if #(
  parameter int LEN_W = 6
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_dest;
  logic [LEN_W-1:0] req_len;
  logic             req_corrupt;
  logic             pl_valid;
  logic [7:0]       pl_data;
  logic             pl_ready;
  logic             busy;
  logic             err;
  logic [7:0]       data_out;
  logic             pkt_valid;
  logic             done;
  logic             tx_err;
  logic             underrun;
  logic             bad_req;

  modport slave (
    input  req_valid, req_dest, req_len, req_corrupt, pl_valid, pl_data, busy, err,
    output req_ready, pl_ready, data_out, pkt_valid, done, tx_err, underrun, bad_req
  );

  modport master (
    output req_valid, req_dest, req_len, req_corrupt, pl_valid, pl_data, busy, err,
    input  req_ready, pl_ready, data_out, pkt_valid, done, tx_err, underrun, bad_req
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: header, payload and even-XOR parity
// byte, with router stall handling, err sampling window and per-packet status.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int LEN_W    = 6,
  parameter int IFG      = 2,
  parameter int ERR_WAIT = 3
) (
  input logic            clock,
  input logic            resetn,
  router_pkt_tx_if.slave bus
);

  localparam int TMR_MAX = (IFG > ERR_WAIT) ? IFG : ERR_WAIT;
  localparam int TMR_W   = $clog2(TMR_MAX + 2);
  localparam logic [TMR_W-1:0] IFG_LD  = TMR_W'(IFG);
  localparam logic [TMR_W-1:0] ERRW_LD = TMR_W'(ERR_WAIT);

  tx_state_t        state, state_nxt;
  logic [7:0]       tx_byte, tx_byte_nxt;
  logic             tx_vld, tx_vld_nxt;
  logic [7:0]       acc, acc_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             inv_par, inv_par_nxt;
  logic             done_pls, done_pls_nxt;
  logic             err_seen, err_seen_nxt;
  logic             under, under_nxt;
  logic             bad_pls, bad_pls_nxt;
  logic             req_rdy, pl_rdy;
  logic [7:0]       hdr;
  logic [7:0]       pay;

  always_comb begin
    hdr = '0;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = 6'(bus.req_len);
    hdr[HDR_DEST_MSB:HDR_DEST_LSB] = bus.req_dest;
  end

  // A missing payload byte is replaced by 0x00 and still counted in parity
  assign pay = bus.pl_valid ? bus.pl_data : 8'h00;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      tx_byte  <= '0;
      tx_vld   <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      tmr      <= IFG_LD;
      inv_par  <= 1'b0;
      done_pls <= 1'b0;
      err_seen <= 1'b0;
      under    <= 1'b0;
      bad_pls  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_byte  <= tx_byte_nxt;
      tx_vld   <= tx_vld_nxt;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      tmr      <= tmr_nxt;
      inv_par  <= inv_par_nxt;
      done_pls <= done_pls_nxt;
      err_seen <= err_seen_nxt;
      under    <= under_nxt;
      bad_pls  <= bad_pls_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tx_byte_nxt  = tx_byte;
    tx_vld_nxt   = tx_vld;
    acc_nxt      = acc;
    cnt_nxt      = cnt;
    tmr_nxt      = tmr;
    inv_par_nxt  = inv_par;
    done_pls_nxt = 1'b0;
    err_seen_nxt = err_seen;
    under_nxt    = under;
    bad_pls_nxt  = 1'b0;
    req_rdy      = 1'b0;
    pl_rdy       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        req_rdy = 1'b1;
        if (bus.req_valid) begin
          err_seen_nxt = 1'b0;
          under_nxt    = 1'b0;
          if (bus.req_dest == DEST_ILLEGAL) begin
            bad_pls_nxt = 1'b1;
          end else begin
            tx_byte_nxt = hdr;
            tx_vld_nxt  = 1'b1;
            acc_nxt     = hdr;
            cnt_nxt     = bus.req_len;
            inv_par_nxt = bus.req_corrupt;
            state_nxt   = ST_HDR;
          end
        end
      end

      ST_HDR, ST_PLD: begin
        // Router stall freezes the current byte and the payload handshake
        if (!bus.busy) begin
          if (cnt != '0) begin
            pl_rdy      = 1'b1;
            tx_byte_nxt = pay;
            acc_nxt     = acc ^ pay;
            cnt_nxt     = cnt - LEN_W'(1);
            if (!bus.pl_valid) under_nxt = 1'b1;
            state_nxt   = ST_PLD;
          end else begin
            tx_byte_nxt = acc ^ {8{inv_par}};
            tx_vld_nxt  = 1'b0;
            state_nxt   = ST_PAR;
          end
        end
      end

      ST_PAR: begin
        if (!bus.busy) begin
          tx_byte_nxt = '0;
          tmr_nxt     = ERRW_LD;
          state_nxt   = ST_ERRW;
        end
      end

      ST_ERRW: begin
        err_seen_nxt = err_seen | bus.err;
        if (tmr <= TMR_W'(1)) begin
          done_pls_nxt = 1'b1;
          tmr_nxt      = IFG_LD;
          state_nxt    = (IFG == 0) ? ST_IDLE : ST_GAP;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end

      ST_GAP: begin
        if (tmr <= TMR_W'(1)) begin
          tmr_nxt   = IFG_LD;
          state_nxt = ST_IDLE;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // req_ready stays low while reset is held even though state already reads IDLE
  assign bus.req_ready = req_rdy & resetn;
  assign bus.pl_ready  = pl_rdy;
  assign bus.data_out  = tx_byte;
  assign bus.pkt_valid = tx_vld;
  assign bus.done      = done_pls;
  assign bus.tx_err    = err_seen;
  assign bus.underrun  = under;
  assign bus.bad_req   = bad_pls;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed literal packets plus randomized traffic
// compared cycle by cycle against a byte-stream model of each packet.
module tb_router_pkt_tx;

  localparam int LEN_W    = 6;
  localparam int IFG      = 2;
  localparam int ERR_WAIT = 3;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  router_pkt_tx_if #(.LEN_W(LEN_W)) bus ();

  router_pkt_tx #(.LEN_W(LEN_W), .IFG(IFG), .ERR_WAIT(ERR_WAIT)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] pl_tab[64];
  bit         pres_tab[64];
  logic [7:0] cap[$];
  int         hold_cnt;
  logic       done_txerr;
  logic       done_under;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected stream: header, payload (absent bytes become 00), parity; each
  // byte is held until a cycle with busy low, then the next one appears.
  task automatic run_pkt(input logic [1:0] dest, input int len, input logic corrupt,
                         input int busy_mode, input int err_mode);
    logic [7:0] ex[66];
    bit         exv[66];
    logic [7:0] par;
    logic [5:0] l6;
    bit         exp_under, err_or, b, e, btrig;
    int         pos, cyc, bleft;
    l6 = len[5:0];
    ex[0] = {l6, dest};
    par = ex[0];
    exp_under = 1'b0;
    for (int i = 0; i < len; i++) begin
      ex[i+1] = pres_tab[i] ? pl_tab[i] : 8'h00;
      par ^= ex[i+1];
      if (!pres_tab[i]) exp_under = 1'b1;
    end
    ex[len+1] = corrupt ? ~par : par;
    for (int i = 0; i < 66; i++) exv[i] = (i <= len);
    cap.delete();
    hold_cnt = 0;

    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_dest = dest; bus.req_len = l6; bus.req_corrupt = corrupt;
    bus.busy = 1'b0; bus.err = 1'b0; bus.pl_valid = 1'b0;
    #1;
    chk("req_ready_idle", bus.req_ready, 1);
    @(posedge clock);
    #1 bus.req_valid = 1'b0;

    if (dest == 2'd3) begin
      @(negedge clock); #1;
      chk("bad_req_pulse", bus.bad_req, 1);
      chk("bad_req_no_pkt", bus.pkt_valid, 0);
      chk("bad_req_ready", bus.req_ready, 1);
      @(negedge clock); #1;
      chk("bad_req_clear", bus.bad_req, 0);
      return;
    end

    pos = 0; cyc = 0; bleft = 0; btrig = 1'b0;
    while (pos <= len + 1) begin
      @(negedge clock);
      case (busy_mode)
        1: b = ($urandom_range(0, 99) < 30);
        2: begin
          if (pos == 2 && !btrig) begin bleft = 2; btrig = 1'b1; end
          b = (bleft > 0);
          if (bleft > 0) bleft--;
        end
        default: b = 1'b0;
      endcase
      bus.busy     = b;
      bus.pl_valid = (pos < len) ? pres_tab[pos] : 1'($urandom_range(0, 1));
      bus.pl_data  = (pos < len) ? pl_tab[pos] : 8'($urandom);
      bus.err      = 1'($urandom_range(0, 1));
      #1;
      chk("data_out", bus.data_out, ex[pos]);
      chk("pkt_valid", bus.pkt_valid, exv[pos]);
      chk("pl_ready", bus.pl_ready, (!b && pos < len));
      chk("req_ready_busy", bus.req_ready, 0);
      chk("done_early", bus.done, 0);
      if (pos == 2) hold_cnt++;
      if (!b) cap.push_back(bus.data_out);
      @(posedge clock);
      if (!b) pos++;
      cyc++;
      if (cyc > 3000) begin
        total++; bad++;
        $display("FAIL tx_timeout: stuck at byte %0d of %0d", pos, len + 2);
        return;
      end
    end

    err_or = 1'b0;
    for (int w = 0; w < ERR_WAIT; w++) begin
      @(negedge clock);
      e = (err_mode == 2) ? 1'b1 : (err_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.err = e;
      bus.busy = 1'($urandom_range(0, 1));
      bus.pl_valid = 1'($urandom_range(0, 1));
      #1;
      chk("win_data", bus.data_out, 0);
      chk("win_pkt_valid", bus.pkt_valid, 0);
      chk("win_done", bus.done, 0);
      chk("win_pl_ready", bus.pl_ready, 0);
      chk("win_req_ready", bus.req_ready, 0);
      err_or |= e;
    end

    @(negedge clock);
    bus.err = 1'b1; bus.busy = 1'b0;
    #1;
    done_txerr = bus.tx_err;
    done_under = bus.underrun;
    chk("done_pulse", bus.done, 1);
    chk("done_tx_err", bus.tx_err, err_or);
    chk("done_underrun", bus.underrun, exp_under);
    chk("gap_req_ready", bus.req_ready, 0);
    for (int g = 1; g < IFG; g++) begin
      @(negedge clock); #1;
      chk("gap_req_ready", bus.req_ready, 0);
      chk("gap_done", bus.done, 0);
    end
    @(negedge clock);
    bus.err = 1'b0;
    #1;
    chk("idle_req_ready", bus.req_ready, 1);
    chk("idle_tx_err_hold", bus.tx_err, err_or);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_dest = '0; bus.req_len = '0; bus.req_corrupt = 1'b0;
    bus.pl_valid = 1'b0; bus.pl_data = '0; bus.busy = 1'b0; bus.err = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_pkt_valid", bus.pkt_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_pl_ready", bus.pl_ready, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tx_err", bus.tx_err, 0);
    chk("rst_underrun", bus.underrun, 0);
    chk("rst_bad_req", bus.bad_req, 0);
    repeat (3) @(posedge clock);
    @(negedge clock) resetn = 1'b1;

    pl_tab[0] = 8'hA5; pl_tab[1] = 8'h3C; pl_tab[2] = 8'h0F;
    pres_tab[0] = 1; pres_tab[1] = 1; pres_tab[2] = 1;
    run_pkt(2'd1, 3, 1'b0, 0, 0);
    chk("t1_nbytes", cap.size(), 5);
    chk("t1_b0", cap[0], 8'h0D);
    chk("t1_b1", cap[1], 8'hA5);
    chk("t1_b2", cap[2], 8'h3C);
    chk("t1_b3", cap[3], 8'h0F);
    chk("t1_par", cap[4], 8'h9B);
    chk("t1_txerr", done_txerr, 0);

    run_pkt(2'd1, 3, 1'b0, 2, 0);
    chk("t2_hold", hold_cnt, 3);
    chk("t2_par", cap[4], 8'h9B);

    run_pkt(2'd2, 0, 1'b0, 0, 0);
    chk("t3_nbytes", cap.size(), 2);
    chk("t3_hdr", cap[0], 8'h02);
    chk("t3_par", cap[1], 8'h02);

    run_pkt(2'd3, 5, 1'b0, 0, 0);

    pl_tab[0] = 8'h11; pl_tab[1] = 8'h77;
    pres_tab[0] = 1; pres_tab[1] = 0;
    run_pkt(2'd2, 2, 1'b0, 0, 0);
    chk("t5_hdr", cap[0], 8'h0A);
    chk("t5_b1", cap[1], 8'h11);
    chk("t5_b2", cap[2], 8'h00);
    chk("t5_par", cap[3], 8'h1B);
    chk("t5_under", done_under, 1);

    pl_tab[0] = 8'hA5; pl_tab[1] = 8'h3C; pl_tab[2] = 8'h0F;
    pres_tab[0] = 1; pres_tab[1] = 1; pres_tab[2] = 1;
    run_pkt(2'd1, 3, 1'b1, 0, 2);
    chk("t6_par_inv", cap[4], 8'h64);
    chk("t6_txerr", done_txerr, 1);

    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_dest = 2'd0; bus.req_len = 6'd5; bus.req_corrupt = 1'b0;
    bus.pl_valid = 1'b1; bus.pl_data = 8'h5A; bus.busy = 1'b0;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("abort_pkt_valid", bus.pkt_valid, 0);
    chk("abort_data_out", bus.data_out, 0);
    chk("abort_pl_ready", bus.pl_ready, 0);
    @(negedge clock) resetn = 1'b1;
    #1;
    chk("abort_idle_ready", bus.req_ready, 1);
    chk("abort_idle_pkt", bus.pkt_valid, 0);
    bus.pl_valid = 1'b0;

    for (int n = 0; n < 40; n++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 12));
      for (int i = 0; i < 64; i++) begin
        pl_tab[i]   = 8'($urandom);
        pres_tab[i] = ($urandom_range(0, 99) < 85);
      end
      run_pkt(2'($urandom_range(0, 3)), len, 1'($urandom_range(0, 1)), 1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
